// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared constants and state type for the SPI frame receiver
package spi_frame_pkg;

    localparam int ADDR_W          = 13;
    localparam int PIXEL_BYTES     = 6144;
    localparam int ATTR_BYTES      = 768;
    localparam int INFO_BYTES      = 256;
    localparam int FRAME_BYTES_DEF = PIXEL_BYTES + ATTR_BYTES + INFO_BYTES;

    localparam logic [ADDR_W-1:0] BORDER_ADDR_DEF = 13'h1B80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall detect on the synchronised level
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain[0] <= sig;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - receives one SPI screen frame into RAM and commits the border colour on vsync
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int                FRAME_BYTES = FRAME_BYTES_DEF,
    parameter logic [ADDR_W-1:0] BORDER_ADDR = BORDER_ADDR_DEF,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_dat,
    input  logic              spi_cs,
    input  logic              vsync_n,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic [2:0]        border,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic dat_lvl, dat_rise, dat_fall;
    logic cs_lvl, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .sig(spi_clk), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dat (
        .clk(clk), .rst(rst), .sig(spi_dat), .level(dat_lvl), .rise(dat_rise), .fall(dat_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .sig(spi_cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, sck_fall, dat_rise, dat_fall, cs_lvl};

    state_t            state, state_nxt;
    logic [7:0]        shift;
    logic [2:0]        bit_cnt;
    logic [ADDR_W-1:0] byte_addr;
    logic [2:0]        staged_val, qual_val;
    logic              staged_valid, qual_valid;
    logic              vsync_prev;

    logic [7:0] next_byte;
    logic       bit_take, byte_done, is_border, is_last, vsync_fall;

    // cs rising takes priority over a coincident SCK edge, so the bit is dropped
    assign bit_take   = (state == ST_RECV) && sck_rise && !cs_rise;
    assign byte_done  = bit_take && (bit_cnt == 3'd7);
    assign next_byte  = {shift[6:0], dat_lvl};
    assign is_border  = (byte_addr == BORDER_ADDR);
    assign is_last    = (byte_addr == LAST_ADDR);
    assign vsync_fall = vsync_prev && !vsync_n;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_RECV;
            ST_RECV: begin
                if (cs_rise)                   state_nxt = ST_IDLE;
                else if (byte_done && is_last) state_nxt = ST_HOLD;
            end
            ST_HOLD: if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift        <= '0;
            bit_cnt      <= '0;
            byte_addr    <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            staged_val   <= '0;
            staged_valid <= 1'b0;
            qual_val     <= '0;
            qual_valid   <= 1'b0;
            border       <= 3'b111;
            vsync_prev   <= 1'b1;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            vsync_prev <= vsync_n;

            if (vsync_fall && qual_valid) begin
                border     <= qual_val;
                qual_valid <= 1'b0;
            end

            if (state == ST_IDLE && cs_fall) begin
                bit_cnt      <= '0;
                byte_addr    <= '0;
                frame_err    <= 1'b0;
                staged_valid <= 1'b0;
            end else if (state == ST_RECV && cs_rise) begin
                if (bit_cnt != 3'd0 || byte_addr != '0) begin
                    frame_err    <= 1'b1;
                    staged_valid <= 1'b0;
                end
                bit_cnt <= '0;
            end else if (bit_take) begin
                shift   <= next_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= byte_addr;
                    wr_data   <= next_byte;
                    byte_addr <= byte_addr + 1'b1;
                    if (is_border) begin
                        staged_val   <= next_byte[2:0];
                        staged_valid <= 1'b1;
                    end
                    // a completed frame promotes its border byte to the vsync-visible slot
                    if (is_last) begin
                        frame_done <= 1'b1;
                        if (is_border || staged_valid) begin
                            qual_val   <= is_border ? next_byte[2:0] : staged_val;
                            qual_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb/tb_spi_frame_ctrl.sv - self-checking bench for spi_frame_ctrl with a reduced frame size
module tb_spi_frame_ctrl;

    localparam int          FB = 48;
    localparam logic [12:0] BA = 13'd40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_dat = 1'b0;
    logic        spi_cs = 1'b1;
    logic        vsync_n = 1'b1;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [2:0]  border;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    spi_frame_ctrl #(.FRAME_BYTES(FB), .BORDER_ADDR(BA), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_dat(spi_dat), .spi_cs(spi_cs),
        .vsync_n(vsync_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .border(border), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_done = 0;
    logic [20:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected RAM image: byte i of a frame lands at address i; frame_done only on the last address
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                n_wr++;
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[20:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                    check("frame_done_on_write", 32'(frame_done), 32'(e[20:8] == 13'(FB - 1)));
                end
            end else begin
                check("frame_done_without_write", 32'(frame_done), 32'd0);
            end
            if (frame_done) n_done++;
        end
    end

    function automatic logic [7:0] byte_of(input int kind, input int i);
        case (kind)
            0:       return 8'(i + 240);
            1:       return (i == int'(BA)) ? 8'h02 : 8'(i * 7);
            2:       return (i == int'(BA)) ? 8'h05 : (8'(i) ^ 8'hA5);
            default: return (i == int'(BA)) ? 8'h06 : 8'(i);
        endcase
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_dat = b[7-i];
            clks(3);
            spi_clk = 1'b1;
            clks(3);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_bytes(input int kind, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = byte_of(kind, i);
            if (i < FB) exp_q.push_back({13'(i), b});
            send_bits(b, 8);
        end
    endtask

    task automatic send_frame(input int kind, input int nbytes, input int extra_bits);
        spi_cs = 1'b0;
        clks(4);
        send_bytes(kind, nbytes);
        if (extra_bits > 0) send_bits(byte_of(kind, nbytes), extra_bits);
        clks(4);
        check("busy_in_frame", 32'(busy), 32'd1);
        spi_cs = 1'b1;
        clks(8);
        check("busy_after_cs", 32'(busy), 32'd0);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_vsync();
        vsync_n = 1'b0;
        clks(3);
        vsync_n = 1'b1;
        clks(2);
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_border", 32'(border), 32'd7);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2 rst = 1'b1;
        clks(3);
        check_reset_outputs();
        rst = 1'b0;
        clks(4);

        // Full frame with a wrapping byte ramp; border byte 0x18 -> colour 000
        send_frame(0, FB, 0);
        check("A_writes", 32'(n_wr), 32'd48);
        check("A_done", 32'(n_done), 32'd1);
        check("A_err", 32'(frame_err), 32'd0);
        check("A_border_before_vsync", 32'(border), 32'd7);
        pulse_vsync();
        check("A_border_after_vsync", 32'(border), 32'd0);

        // Two bytes beyond the frame must be ignored; border byte 0x02
        send_frame(1, FB + 2, 0);
        check("B_writes", 32'(n_wr), 32'd96);
        check("B_done", 32'(n_done), 32'd2);
        check("B_border_before_vsync", 32'(border), 32'd0);
        pulse_vsync();
        check("B_border_after_vsync", 32'(border), 32'd2);

        // Short frame reaching the border byte: error, colour not committed
        send_frame(2, 45, 3);
        check("C_writes", 32'(n_wr), 32'd141);
        check("C_done", 32'(n_done), 32'd2);
        check("C_err", 32'(frame_err), 32'd1);
        pulse_vsync();
        check("C_border_after_vsync", 32'(border), 32'd2);

        // Empty select: no error, no writes
        send_frame(2, 0, 0);
        check("D_err", 32'(frame_err), 32'd0);
        check("D_writes", 32'(n_wr), 32'd141);

        // Reset in the middle of byte 20
        spi_cs = 1'b0;
        clks(4);
        send_bytes(3, 20);
        send_bits(8'hFF, 4);
        rst = 1'b1;
        spi_cs = 1'b1;
        spi_clk = 1'b0;
        clks(1);
        check_reset_outputs();
        clks(2);
        rst = 1'b0;
        clks(8);
        check("E_writes", 32'(n_wr), 32'd161);
        check("E_queue_empty", 32'(exp_q.size()), 32'd0);
        check("E_busy", 32'(busy), 32'd0);

        // Clean frame after reset, border byte 0x06
        send_frame(3, FB, 0);
        check("F_writes", 32'(n_wr), 32'd209);
        check("F_done", 32'(n_done), 32'd3);
        check("F_err", 32'(frame_err), 32'd0);
        check("F_border_before_vsync", 32'(border), 32'd7);
        pulse_vsync();
        check("F_border_after_vsync", 32'(border), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 7168, meaning bytes per frame (6144 pixel + 768 attribute + 256 info).
REQ-002 SHALL have parameter BORDER_ADDR, default 13'h1B80, meaning the frame byte offset that carries the border colour.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop stages on each asynchronous SPI input.
REQ-004 SHALL have port clk, input, 1 bit: the single clock (LCD pixel clock, 9 MHz); spi_clk SHALL be at most clk/4.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port spi_clk, input, 1 bit: SPI SCK, asynchronous to clk, data sampled on its rising edge.
REQ-007 SHALL have port spi_dat, input, 1 bit: SPI MOSI, MSB first.
REQ-008 SHALL have port spi_cs, input, 1 bit: chip select, active-low, asynchronous.
REQ-009 SHALL have port vsync_n, input, 1 bit: LCD vertical sync, active-low, synchronous to clk.
REQ-010 SHALL have port wr_addr, output, 13 bits: screen RAM write address.
REQ-011 SHALL have port wr_data, output, 8 bits: screen RAM write data.
REQ-012 SHALL have port wr_en, output, 1 bit: single-cycle RAM write strobe.
REQ-013 SHALL have port border, output, 3 bits: committed border colour {G,R,B}.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-015 SHALL have port frame_err, output, 1 bit: sticky short-frame flag.
REQ-016 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-017 SHALL pass spi_clk, spi_dat and spi_cs through SYNC_STAGES flip-flops each, all with equal delay, and detect edges only on the synchronised signals.
REQ-018 SHALL implement states IDLE, RECV and HOLD.
REQ-019 IDLE -> RECV on synchronised spi_cs falling edge; SHALL clear bit count, byte address and frame_err.
REQ-020 In RECV, SHALL shift in synchronised spi_dat on each synchronised spi_clk rising edge, MSB first.
REQ-021 On the 8th bit, SHALL assert wr_en for exactly one cycle, on the cycle after the edge is detected, with wr_addr = current byte address and wr_data = assembled byte; the byte address SHALL then increment by 1.
REQ-022 When the byte at address FRAME_BYTES-1 is written, SHALL pulse frame_done on the same cycle as that wr_en and enter HOLD.
REQ-023 In HOLD, SHALL ignore further SCK edges (no wr_en, no address wrap); HOLD -> IDLE on spi_cs rising edge.
REQ-024 On spi_cs rising edge in RECV with any bit or byte received, SHALL set frame_err, discard any partial byte and enter IDLE.
REQ-025 On spi_cs rising edge in RECV with zero bits received, SHALL enter IDLE without error.
REQ-026 A byte written at BORDER_ADDR SHALL have its bits [2:0] latched into a pending register, and a pending-valid flag SHALL be set.
REQ-027 Pending-valid SHALL be qualified by frame_done; on frame_err the pending value SHALL be discarded.
REQ-028 On a vsync_n falling edge while a qualified pending value exists, SHALL update border with it on the next cycle and clear pending-valid.
REQ-029 If SCK rising edge and spi_cs rising edge are detected in the same cycle, cs SHALL take priority and the bit SHALL be dropped.

Reset
REQ-030 rst SHALL force state IDLE, synchroniser flops to spi_cs=1/spi_clk=0, wr_en=0, wr_addr=0, wr_data=0, border=3'b111, frame_done=0, frame_err=0, busy=0, pending cleared.
REQ-031 rst asserted mid-frame SHALL abort with no further wr_en; after release, the block SHALL wait for a fresh spi_cs falling edge.

Structure
REQ-032 Shared package spi_frame_pkg SHALL hold FRAME_BYTES, BORDER_ADDR defaults, the pixel/attr/info region sizes and the state enum.
REQ-033 Synchroniser plus edge detect SHALL be one sub-module, spi_sync_edge, instantiated per SPI input.

Verification
REQ-034 Full frame of 7168 bytes with bytes 0x00..0xFF repeating -> 7168 wr_en pulses, addr 0..7167, data matches, one frame_done on the last write, busy low after cs rises.
REQ-035 Frame with byte 0x1B80 = 0x02 -> border stays 3'b111 until the next vsync_n fall, then becomes 3'b010.
REQ-036 cs rises after 100 bytes + 3 bits -> 100 wr_en pulses, frame_err=1, border unchanged at next vsync.
REQ-037 7170 bytes sent -> exactly 7168 wr_en pulses and no address wrap to 0.
REQ-038 rst pulse during byte 50 -> wr_en stops, all outputs at reset values; next full frame writes correctly from address 0 with frame_err=0.
